// File: rtl/nco_cordic_phase_det_if.sv
// Sample/result bus between the NCO and the CORDIC phase detector.
// master = upstream sample source, slave = the detector.
interface nco_cordic_phase_det_if #(
  parameter int mpr  = 12,
  parameter int apri = 16
);
  logic                   in_valid;
  logic signed [mpr-1:0]  fcos_i;
  logic signed [mpr-1:0]  fsin_i;
  logic                   in_ready;
  logic [apri-1:0]        phase_o;
  logic [mpr:0]           mag_o;
  logic                   out_valid;

  modport master (
    output in_valid, fcos_i, fsin_i,
    input  in_ready, phase_o, mag_o, out_valid
  );

  modport slave (
    input  in_valid, fcos_i, fsin_i,
    output in_ready, phase_o, mag_o, out_valid
  );
endinterface

// File: rtl/nco_cordic_phase_det.sv
// Iterative vectoring-mode CORDIC: converts an NCO sin/cos sample into
// phase (fraction of a turn) and uncompensated magnitude, one iteration per enabled cycle.
module nco_cordic_phase_det #(
  parameter int mpr  = 12,
  parameter int apri = 16,
  parameter int iter = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  nco_cordic_phase_det_if.slave bus
);

  localparam int W  = mpr + 2;
  localparam int CW = $clog2(iter);

  typedef enum logic {IDLE, ROT} state_t;

  // atan(1/n) in Q64 radians by power series; only evaluated at elaboration.
  function automatic logic [127:0] atan_inv_q64(input logic [127:0] n);
    logic [127:0] one, p, acc, t;
    one = 128'd1 << 64;
    p   = n;
    acc = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      if (p <= one) begin
        t   = one / p / 128'(2 * k + 1);
        acc = (k % 2 == 0) ? acc + t : acc - t;
        p   = p * n * n;
      end
    end
    return acc;
  endfunction

  // Turn-scaled angle, normalised against pi/4 (Machin) so entry 0 is exact.
  function automatic logic [apri-1:0] atan_turns(input int unsigned i);
    logic [127:0] quarter, num;
    if (i == 0) begin
      return apri'(1 << (apri - 3));
    end else begin
      quarter = (atan_inv_q64(128'd5) << 2) - atan_inv_q64(128'd239);
      num     = atan_inv_q64(128'd1 << i) << (apri - 2);
      return apri'(((num / quarter) + 128'd1) >> 1);
    end
  endfunction

  logic [apri-1:0] atan_lut [iter];

  for (genvar g = 0; g < iter; g++) begin : g_atan
    localparam logic [apri-1:0] ATAN_G = atan_turns(g);
    assign atan_lut[g] = ATAN_G;
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   x_q, x_d, y_q, y_d;
  logic [apri-1:0]       z_q, z_d;
  logic [apri-1:0]       phase_q, phase_d;
  logic [mpr:0]          mag_q, mag_d;
  logic                  vld_q, vld_d;
  logic                  zero_q, zero_d;

  logic signed [W-1:0]   fc_ext, fs_ext, xs, ys, x_n, y_n;
  logic [apri-1:0]       z_n;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.phase_o   = phase_q;
  assign bus.mag_o     = mag_q;
  assign bus.out_valid = vld_q;

  always_comb begin
    fc_ext = {{2{bus.fcos_i[mpr-1]}}, bus.fcos_i};
    fs_ext = {{2{bus.fsin_i[mpr-1]}}, bus.fsin_i};
    xs     = x_q >>> cnt_q;
    ys     = y_q >>> cnt_q;
    if (!y_q[W-1]) begin
      x_n = x_q + ys;
      y_n = y_q - xs;
      z_n = z_q + atan_lut[cnt_q];
    end else begin
      x_n = x_q - ys;
      y_n = y_q + xs;
      z_n = z_q - atan_lut[cnt_q];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    phase_d = phase_q;
    mag_d   = mag_q;
    vld_d   = 1'b0;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ROT;
          cnt_d   = '0;
          zero_d  = (bus.fcos_i == '0) && (bus.fsin_i == '0);
          // Left half-plane is folded by 180 deg so the iterations only span +/-90.
          if (bus.fcos_i[mpr-1]) begin
            x_d = -fc_ext;
            y_d = -fs_ext;
            z_d = {1'b1, {(apri-1){1'b0}}};
          end else begin
            x_d = fc_ext;
            y_d = fs_ext;
            z_d = '0;
          end
        end
      end
      ROT: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        if (cnt_q == CW'(iter - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = zero_q ? '0 : z_n;
          mag_d   = zero_q ? '0 : x_n[mpr:0];
          vld_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      phase_q <= '0;
      mag_q   <= '0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      phase_q <= phase_d;
      mag_q   <= mag_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_nco_cordic_phase_det.sv
// Scoreboard bench for nco_cordic_phase_det: a loop-level CORDIC reference plus an
// acceptance/latency model predicts every result; a negedge monitor checks them.
module tb_nco_cordic_phase_det;

  localparam int MPR  = 12;
  localparam int APRI = 16;
  localparam int ITER = 14;
  localparam real PI  = 3.14159265358979323846;
  localparam int  COARSE_PH_TOL  = 24;
  localparam real COARSE_MAG_TOL = 16.0;

  logic clk, reset_n, clken;

  nco_cordic_phase_det_if #(.mpr(MPR), .apri(APRI)) bus ();

  nco_cordic_phase_det #(.mpr(MPR), .apri(APRI), .iter(ITER)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .bus     (bus)
  );

  typedef struct {
    int  phase;
    int  mag;
    int  due;
    bit  ideal_chk;
    int  ideal_ph;
    real ideal_mag;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   en_cnt    = 0;
  int   busy_left = 0;
  bit   last_en   = 0;
  bit   want_ideal = 0;
  int   atan_tab [ITER];
  real  kgain;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Vectoring CORDIC as a plain loop on unbounded integers.
  function automatic void ref_model(input int fc, input int fs, output int ph, output int mag);
    int x, y, z, xn, yn;
    if (fc == 0 && fs == 0) begin
      ph = 0; mag = 0;
      return;
    end
    if (fc < 0) begin x = -fc; y = -fs; z = 32768; end
    else        begin x = fc;  y = fs;  z = 0;     end
    for (int i = 0; i < ITER; i++) begin
      if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i]; end
      else        begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i]; end
      x = xn; y = yn;
    end
    ph  = z & 32'hFFFF;
    mag = x & 32'h1FFF;
  endfunction

  // Acceptance / busy model, evaluated on every rising edge.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      sb.delete();
      busy_left = 0;
      last_en   = 0;
    end else begin
      last_en = clken;
      if (clken) begin
        en_cnt++;
        if (busy_left != 0) begin
          busy_left--;
        end else if (bus.in_valid) begin
          exp_t e;
          int fc, fs;
          real ph;
          fc = int'(bus.fcos_i);
          fs = int'(bus.fsin_i);
          ref_model(fc, fs, e.phase, e.mag);
          e.due       = en_cnt + ITER;
          e.ideal_chk = want_ideal;
          ph = $atan2(real'(fs), real'(fc)) / (2.0 * PI) * 65536.0;
          if (ph < 0.0) ph = ph + 65536.0;
          e.ideal_ph  = int'(ph) & 32'hFFFF;
          e.ideal_mag = kgain * $sqrt(real'(fc * fc + fs * fs));
          sb.push_back(e);
          busy_left = ITER;
        end
      end
    end
  end

  // Monitor: sampled half a cycle after each rising edge.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("in_ready", int'(bus.in_ready), int'(busy_left == 0));
      if (last_en && bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          int d;
          real md;
          e = sb.pop_front();
          chk("phase", int'(bus.phase_o), e.phase);
          chk("mag", int'(bus.mag_o), e.mag);
          chk("latency_edge", en_cnt, e.due);
          if (e.ideal_chk) begin
            d = (int'(bus.phase_o) - e.ideal_ph) & 32'hFFFF;
            if (d >= 32768) d = d - 65536;
            if (d < 0) d = -d;
            chk("phase_vs_atan2_within_tol", int'(d <= COARSE_PH_TOL), 1);
            md = real'(bus.mag_o) - e.ideal_mag;
            if (md < 0.0) md = -md;
            chk("mag_vs_ideal_within_tol", int'(md <= COARSE_MAG_TOL), 1);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || busy_left != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_in_budget", int'(n < bound), 1);
  endtask

  task automatic send(input int fc, input int fs, input bit ideal);
    bus.fcos_i   = 12'(fc);
    bus.fsin_i   = 12'(fs);
    bus.in_valid = 1'b1;
    want_ideal   = ideal;
    tick();
    bus.in_valid = 1'b0;
    want_ideal   = 1'b0;
    wait_drain(200);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_phase"}, int'(bus.phase_o), 0);
    chk({tag, "_mag"}, int'(bus.mag_o), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    kgain = 1.0;
    for (int i = 0; i < ITER; i++) begin
      atan_tab[i] = int'($atan(1.0 / real'(1 << i)) / (2.0 * PI) * 65536.0);
      kgain = kgain * $sqrt(1.0 + 1.0 / real'(1 << (2 * i)));
    end
    chk("atan_0", atan_tab[0], 8192);
    chk("atan_1", atan_tab[1], 4836);

    reset_n      = 1'b0;
    clken        = 1'b1;
    bus.in_valid = 1'b0;
    bus.fcos_i   = '0;
    bus.fsin_i   = '0;
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;

    // Directed axis/diagonal/zero/near-wrap vectors; first one on the first edge after release.
    send(2047, 0, 1);
    send(0, 2047, 1);
    send(-2048, 0, 1);
    send(0, -2048, 1);
    send(1448, 1448, 1);
    send(0, 0, 0);
    send(2047, -1, 1);
    send(-2048, -2048, 0);

    // Random clken and in_valid with a changing sample each cycle.
    for (int t = 0; t < 800; t++) begin
      clken        = ($urandom_range(0, 1) == 1);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.fcos_i   = 12'(rnd_s());
      bus.fsin_i   = 12'(rnd_s());
      tick();
    end
    clken        = 1'b1;
    bus.in_valid = 1'b0;
    wait_drain(200);

    // Back-to-back: in_valid held high, new sample every cycle.
    bus.in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      bus.fcos_i = 12'(rnd_s());
      bus.fsin_i = 12'(rnd_s());
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain(200);

    // Reset during iteration 5 aborts the sample; the next one must be clean.
    bus.fcos_i   = 12'(1000);
    bus.fsin_i   = 12'(-700);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check_reset_values("midrot_reset");
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("no_pending_after_abort", sb.size(), 0);
    send(1448, 1448, 1);
    send(-1200, 900, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
